// File: rtl/sar_pkg.sv
// Shared state encodings and comparator flag codes for the SAR search controller.
package sar_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TEST = 1'b1
    } sar_state_e;

    // Flag codes are ordered {gt, eq, lt}.
    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/sar_flag_check.sv
// Validates the comparator's {gt,eq,lt} flags and decodes them.
// Decoded outputs are only asserted when the flags are exactly one-hot.
module sar_flag_check
    import sar_pkg::*;
(
    input  logic [2:0] flags_i,
    output logic       onehot_ok_o,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);

    always_comb begin
        onehot_ok_o = (flags_i == FLAG_GT) || (flags_i == FLAG_EQ) || (flags_i == FLAG_LT);
        gt_o        = (flags_i == FLAG_GT);
        eq_o        = (flags_i == FLAG_EQ);
        lt_o        = (flags_i == FLAG_LT);
    end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller: binary-searches an external comparator's
// unknown operand by driving trial values and sampling its gt/eq/lt flags.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int         IW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [3:0]       settle_q, settle_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             onehot_ok, f_gt, f_eq, f_lt;
    logic             finish;
    logic [WIDTH-1:0] cur_bit, lower_bit;

    sar_flag_check u_flag_check (
        .flags_i     ({cmp_gt, cmp_eq, cmp_lt}),
        .onehot_ok_o (onehot_ok),
        .gt_o        (f_gt),
        .eq_o        (f_eq),
        .lt_o        (f_lt)
    );

    assign cur_bit   = WIDTH'(1) << bit_idx_q;
    assign lower_bit = cur_bit >> 1;

    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        bit_idx_d = bit_idx_q;
        settle_d  = settle_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        finish    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    trial_d   = WIDTH'(1) << (WIDTH - 1);
                    bit_idx_d = IW'(WIDTH - 1);
                    settle_d  = SETTLE_INIT;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    state_d   = ST_TEST;
                end
            end
            ST_TEST: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else if (!onehot_ok) begin
                    err_d    = 1'b1;
                    result_d = trial_q;
                    finish   = 1'b1;
                end else if (f_eq) begin
                    result_d = trial_q;
                    finish   = 1'b1;
                end else if (bit_idx_q != '0) begin
                    trial_d   = f_gt ? (trial_q | lower_bit)
                                     : ((trial_q & ~cur_bit) | lower_bit);
                    bit_idx_d = bit_idx_q - IW'(1);
                    settle_d  = SETTLE_INIT;
                end else if (f_lt) begin
                    result_d = trial_q & ~cur_bit;
                    finish   = 1'b1;
                end else begin
                    // gt on the last bit means the comparator contradicted itself
                    err_d    = 1'b1;
                    result_d = trial_q;
                    finish   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            trial_d = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            trial_q   <= '0;
            result_q  <= '0;
            bit_idx_q <= '0;
            settle_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            trial_q   <= trial_d;
            result_q  <= result_d;
            bit_idx_q <= bit_idx_d;
            settle_q  <= settle_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (SETTLE=0 and SETTLE=2), each beside a
// behavioural comparator; table vectors, corner sequences and random unknowns.
module tb_sar_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SETTLE=0 instance with flag override for fault injection
    logic       rst0, start0, ovr0;
    logic [2:0] ovrv0;
    logic [3:0] u0;
    logic       gt0, eq0, lt0;
    logic [3:0] trial0, result0;
    logic       busy0, done0, err0;

    // SETTLE=2 instance
    logic       rst2, start2;
    logic [3:0] u2;
    logic       gt2, eq2, lt2;
    logic [3:0] trial2, result2;
    logic       busy2, done2, err2;

    always_comb begin
        if (ovr0) {gt0, eq0, lt0} = ovrv0;
        else      {gt0, eq0, lt0} = {u0 > trial0, u0 == trial0, u0 < trial0};
        {gt2, eq2, lt2} = {u2 > trial2, u2 == trial2, u2 < trial2};
    end

    sar_search_ctrl #(.WIDTH(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0),
        .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
        .trial(trial0), .busy(busy0), .done(done0), .result(result0), .err(err0)
    );

    sar_search_ctrl #(.WIDTH(4), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2),
        .cmp_gt(gt2), .cmp_eq(eq2), .cmp_lt(lt2),
        .trial(trial2), .busy(busy2), .done(done2), .result(result2), .err(err2)
    );

    // Selected-instance view used by the shared search task
    int         sel = 0;
    logic [3:0] o_trial, o_result;
    logic       o_busy, o_done, o_err;
    always_comb begin
        o_trial  = (sel != 0) ? trial2  : trial0;
        o_result = (sel != 0) ? result2 : result0;
        o_busy   = (sel != 0) ? busy2   : busy0;
        o_done   = (sel != 0) ? done2   : done0;
        o_err    = (sel != 0) ? err2    : err0;
    end

    always @(negedge clk) begin
        checks++;
        if ((done0 && busy0) || (done2 && busy2)) begin
            errors++;
            $display("FAIL done_busy_overlap: dut0 %0b%0b dut2 %0b%0b, required never both 1",
                     done0, busy0, done2, busy2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start2 = v;
        else          start0 = v;
    endtask

    task automatic set_u(input int v);
        if (sel != 0) u2 = 4'(v);
        else          u0 = 4'(v);
    endtask

    // Reference: interval binary search over [lo, lo + 2^(i+1))
    int m_trials[4];
    int m_n;
    int m_res;
    task automatic model(input int u);
        int lo;
        int t;
        lo  = 0;
        m_n = 0;
        m_res = 0;
        for (int i = 3; i >= 0; i--) begin
            t = lo + (1 << i);
            m_trials[m_n] = t;
            m_n++;
            if (u == t) begin
                m_res = t;
                return;
            end
            if (u > t) lo = t;
        end
        m_res = lo;
    endtask

    task automatic run_search(input string tag, input int u, input int n,
                              input int t0, input int t1, input int t2, input int t3,
                              input int res);
        int tr[4];
        int s_cnt;
        tr    = '{t0, t1, t2, t3};
        s_cnt = (sel != 0) ? 2 : 0;
        set_u(u);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c <= s_cnt; c++) begin
                chk($sformatf("%s u=%0d step%0d cyc%0d trial", tag, u, s, c), o_trial, tr[s]);
                chk($sformatf("%s u=%0d step%0d busy", tag, u, s), o_busy, 1);
                tick();
            end
        end
        chk($sformatf("%s u=%0d done", tag, u), o_done, 1);
        chk($sformatf("%s u=%0d busy_at_done", tag, u), o_busy, 0);
        chk($sformatf("%s u=%0d result", tag, u), o_result, res);
        chk($sformatf("%s u=%0d err", tag, u), o_err, 0);
        chk($sformatf("%s u=%0d trial_at_done", tag, u), o_trial, 0);
        tick();
        chk($sformatf("%s u=%0d done_one_cycle", tag, u), o_done, 0);
        chk($sformatf("%s u=%0d result_held", tag, u), o_result, res);
    endtask

    typedef struct {
        int sel;
        int u;
        int n;
        int t0, t1, t2, t3;
        int res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0,  8, 1, 8,  0,  0,  0,  8};
        vecs[1] = '{0,  5, 4, 8,  4,  6,  5,  5};
        vecs[2] = '{0,  0, 4, 8,  4,  2,  1,  0};
        vecs[3] = '{0, 15, 4, 8, 12, 14, 15, 15};
        vecs[4] = '{1,  9, 4, 8, 12, 10,  9,  9};
        vecs[5] = '{1,  0, 4, 8,  4,  2,  1,  0};

        rst0 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start2 = 1'b0;
        ovr0 = 1'b0; ovrv0 = 3'b000;
        u0 = 4'd0; u2 = 4'd0;
        tick();
        tick();
        chk("reset trial0", trial0, 0);
        chk("reset busy0", busy0, 0);
        chk("reset done0", done0, 0);
        chk("reset result0", result0, 0);
        chk("reset err0", err0, 0);
        chk("reset trial2", trial2, 0);
        chk("reset busy2", busy2, 0);
        rst0 = 1'b0; rst2 = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            run_search($sformatf("vec%0d", i), vecs[i].u, vecs[i].n,
                       vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].res);
        end

        // Inconsistent flags on the second sample
        sel = 0;
        u0 = 4'd3;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("badflag trial first", trial0, 8);
        tick();
        chk("badflag trial second", trial0, 4);
        ovr0 = 1'b1; ovrv0 = 3'b110;
        tick();
        chk("badflag done", done0, 1);
        chk("badflag err", err0, 1);
        chk("badflag result", result0, 4);
        chk("badflag busy", busy0, 0);
        ovr0 = 1'b0;
        tick();
        chk("badflag err held", err0, 1);
        run_search("after_err", 3, 4, 8, 4, 2, 3, 3);

        // Reset mid-search with bit_idx=1
        u0 = 4'd6;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        chk("midrst trial before", trial0, 6);
        rst0 = 1'b1;
        tick();
        chk("midrst trial", trial0, 0);
        chk("midrst busy", busy0, 0);
        chk("midrst done", done0, 0);
        rst0 = 1'b0;
        tick();
        chk("midrst no done", done0, 0);
        chk("midrst idle", busy0, 0);

        // Start held through a search: ignored while busy, accepted in the done cycle
        u0 = 4'd5;
        start0 = 1'b1;
        tick();
        chk("hold trial 8", trial0, 8);
        tick();
        chk("hold trial 4 (start ignored)", trial0, 4);
        tick();
        chk("hold trial 6", trial0, 6);
        tick();
        chk("hold trial 5", trial0, 5);
        tick();
        chk("hold done", done0, 1);
        chk("hold result", result0, 5);
        tick();
        chk("restart trial", trial0, 8);
        chk("restart busy", busy0, 1);
        chk("restart done", done0, 0);
        start0 = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("restart done2", done0, 1);
        chk("restart result", result0, 5);
        tick();

        // Random unknowns against the reference model, alternating instances
        for (int it = 0; it < 32; it++) begin
            int u;
            sel = it % 2;
            u   = int'($urandom_range(0, 15));
            model(u);
            run_search($sformatf("rnd%0d", it), u, m_n,
                       m_trials[0], (m_n > 1) ? m_trials[1] : 0,
                       (m_n > 2) ? m_trials[2] : 0, (m_n > 3) ? m_trials[3] : 0, m_res);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
